// File: rtl/wb_vertex_assembler.sv
// wb_vertex_assembler: writeback-stage graphics back end.
// Takes retired graphics commands (BEGIN/VERTEX/COLOR/END), assembles points,
// lines, triangle lists and triangle strips, and holds each finished primitive
// in a one-entry output register until the GPU stage takes it.
// Ports:
//   I_CLOCK, I_RESET        clock (state updates on falling edge), async active-high reset
//   I_LOCK                  pipeline run; low flushes the assembler
//   I_Valid, I_Cmd          command handshake and opcode
//   I_PrimType              primitive type carried by BEGIN
//   I_VertexData            vertex word carried by VERTEX
//   I_ColorData             colour word carried by COLOR
//   I_GPUStallSignal        downstream cannot take a primitive this cycle
//   O_Ready                 command will be accepted at next edge
//   O_PrimValid/PrimType/Vertices/Color   held primitive
//   O_GSRValue, O_GSRValue_Valid          status snapshot and its update pulse
//   O_Error                 one-cycle protocol error pulse
module wb_vertex_assembler #(
    parameter int unsigned VTX_W   = 30,
    parameter int unsigned COLOR_W = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET,
    input  logic                 I_LOCK,
    input  logic                 I_Valid,
    input  logic [2:0]           I_Cmd,
    input  logic [1:0]           I_PrimType,
    input  logic [VTX_W-1:0]     I_VertexData,
    input  logic [COLOR_W-1:0]   I_ColorData,
    input  logic                 I_GPUStallSignal,
    output logic                 O_Ready,
    output logic                 O_PrimValid,
    output logic [1:0]           O_PrimType,
    output logic [3*VTX_W-1:0]   O_Vertices,
    output logic [COLOR_W-1:0]   O_Color,
    output logic [CNT_W+7:0]     O_GSRValue,
    output logic                 O_GSRValue_Valid,
    output logic                 O_Error
);

    typedef enum logic {StIdle, StCollect} state_t;

    localparam logic [1:0] PrimStrip = 2'd3;

    state_t             state;
    logic [1:0]         vc;
    logic               strip_full;  // strip window holds three valid vertices
    logic [VTX_W-1:0]   w0, w1, w2;
    logic [1:0]         prim_type;
    logic [COLOR_W-1:0] color;
    logic [CNT_W-1:0]   prim_cnt;
    logic [3:0]         err_cnt;

    logic               accept;
    logic               cmd_begin, cmd_vertex, cmd_color, cmd_end;
    logic [1:0]         last_idx;
    logic               complete;
    logic               end_partial;
    logic               err_evt;
    logic               prim_valid_nxt;
    logic [3:0]         err_cnt_nxt;
    logic [CNT_W-1:0]   prim_cnt_nxt;
    logic [3*VTX_W-1:0] prim_vertices;

    assign O_Ready = ~O_PrimValid | ~I_GPUStallSignal;
    assign accept  = I_Valid & O_Ready & I_LOCK;

    always_comb begin
        cmd_begin  = accept & (I_Cmd == 3'd1);
        cmd_vertex = accept & (I_Cmd == 3'd2);
        cmd_color  = accept & (I_Cmd == 3'd3);
        cmd_end    = accept & (I_Cmd == 3'd4);

        case (prim_type)
            2'd0:    last_idx = 2'd0;
            2'd1:    last_idx = 2'd1;
            default: last_idx = 2'd2;
        endcase

        complete = cmd_vertex & (state == StCollect) & (vc == last_idx);

        // A strip is only well formed once it has produced a triangle.
        end_partial = (prim_type == PrimStrip) ? ~strip_full : (vc != 2'd0);

        err_evt = (cmd_begin  & (state == StCollect)) |
                  (cmd_vertex & (state == StIdle)) |
                  (cmd_end    & ((state == StIdle) | end_partial));

        err_cnt_nxt    = (err_evt && err_cnt != 4'd15) ? err_cnt + 4'd1 : err_cnt;
        prim_cnt_nxt   = prim_cnt + {{(CNT_W-1){1'b0}}, complete};
        prim_valid_nxt = complete | (O_PrimValid & I_GPUStallSignal);

        case (prim_type)
            2'd0:    prim_vertices = {{VTX_W{1'b0}}, {VTX_W{1'b0}}, I_VertexData};
            2'd1:    prim_vertices = {{VTX_W{1'b0}}, I_VertexData, w0};
            2'd2:    prim_vertices = {I_VertexData, w1, w0};
            default: prim_vertices = strip_full ? {I_VertexData, w2, w1}
                                                : {I_VertexData, w1, w0};
        endcase
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state            <= StIdle;
            vc               <= 2'd0;
            strip_full       <= 1'b0;
            w0               <= '0;
            w1               <= '0;
            w2               <= '0;
            prim_type        <= 2'd0;
            color            <= '0;
            prim_cnt         <= '0;
            err_cnt          <= 4'd0;
            O_PrimValid      <= 1'b0;
            O_PrimType       <= 2'd0;
            O_Vertices       <= '0;
            O_Color          <= '0;
            O_GSRValue       <= '0;
            O_GSRValue_Valid <= 1'b0;
            O_Error          <= 1'b0;
        end else begin
            O_Error          <= 1'b0;
            O_GSRValue_Valid <= 1'b0;
            if (!I_LOCK) begin
                // Flush: drop any partial primitive and the held one; keep counters/colour.
                state       <= StIdle;
                vc          <= 2'd0;
                strip_full  <= 1'b0;
                O_PrimValid <= 1'b0;
            end else begin
                O_PrimValid <= prim_valid_nxt;
                O_Error     <= err_evt;
                err_cnt     <= err_cnt_nxt;
                prim_cnt    <= prim_cnt_nxt;
                if (complete) begin
                    O_PrimType <= prim_type;
                    O_Vertices <= prim_vertices;
                    O_Color    <= color;
                end
                if (cmd_color) begin
                    color <= I_ColorData;
                end
                case (state)
                    StIdle: begin
                        if (cmd_begin) begin
                            state      <= StCollect;
                            prim_type  <= I_PrimType;
                            vc         <= 2'd0;
                            strip_full <= 1'b0;
                        end
                    end
                    default: begin
                        if (cmd_begin) begin
                            prim_type  <= I_PrimType;
                            vc         <= 2'd0;
                            strip_full <= 1'b0;
                        end else if (cmd_vertex) begin
                            if (prim_type == PrimStrip && strip_full) begin
                                // Slide the strip window by one vertex.
                                w0 <= w1;
                                w1 <= w2;
                                w2 <= I_VertexData;
                            end else begin
                                case (vc)
                                    2'd0:    w0 <= I_VertexData;
                                    2'd1:    w1 <= I_VertexData;
                                    default: w2 <= I_VertexData;
                                endcase
                                if (!complete) begin
                                    vc <= vc + 2'd1;
                                end else if (prim_type == PrimStrip) begin
                                    strip_full <= 1'b1;  // vc stays at 2 for the rest of the strip
                                end else begin
                                    vc <= 2'd0;
                                end
                            end
                        end else if (cmd_end) begin
                            state            <= StIdle;
                            vc               <= 2'd0;
                            strip_full       <= 1'b0;
                            O_GSRValue_Valid <= 1'b1;
                            // in_prim field is 0: the snapshot reflects the post-END IDLE state.
                            O_GSRValue       <= {prim_cnt_nxt, err_cnt_nxt, prim_type, 1'b0,
                                                 prim_valid_nxt};
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_vertex_assembler.sv
module tb_wb_vertex_assembler;

    localparam int VW = 30;
    localparam int CW = 16;
    localparam int NW = 8;

    logic            clk;
    logic            I_RESET, I_LOCK, I_Valid, I_GPUStallSignal;
    logic [2:0]      I_Cmd;
    logic [1:0]      I_PrimType;
    logic [VW-1:0]   I_VertexData;
    logic [CW-1:0]   I_ColorData;
    logic            O_Ready, O_PrimValid, O_GSRValue_Valid, O_Error;
    logic [1:0]      O_PrimType;
    logic [3*VW-1:0] O_Vertices;
    logic [CW-1:0]   O_Color;
    logic [NW+7:0]   O_GSRValue;

    wb_vertex_assembler #(.VTX_W(VW), .COLOR_W(CW), .CNT_W(NW)) dut (
        .I_CLOCK(clk), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_Valid(I_Valid),
        .I_Cmd(I_Cmd), .I_PrimType(I_PrimType), .I_VertexData(I_VertexData),
        .I_ColorData(I_ColorData), .I_GPUStallSignal(I_GPUStallSignal),
        .O_Ready(O_Ready), .O_PrimValid(O_PrimValid), .O_PrimType(O_PrimType),
        .O_Vertices(O_Vertices), .O_Color(O_Color), .O_GSRValue(O_GSRValue),
        .O_GSRValue_Valid(O_GSRValue_Valid), .O_Error(O_Error)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Behavioural reference: vertex queue per primitive, output slot, counters.
    bit              m_in_prim;
    logic [1:0]      m_type;
    logic [VW-1:0]   m_verts[$];
    logic [CW-1:0]   m_color;
    logic [NW-1:0]   m_pc;
    logic [3:0]      m_ec;
    bit              m_ovalid;
    logic [1:0]      m_otype;
    logic [3*VW-1:0] m_overts;
    logic [CW-1:0]   m_ocolor;
    logic [NW+7:0]   m_gsr;
    bit              m_gsrv, m_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_in_prim = 0; m_type = 0; m_verts.delete(); m_color = 0; m_pc = 0; m_ec = 0;
        m_ovalid = 0; m_otype = 0; m_overts = 0; m_ocolor = 0; m_gsr = 0;
        m_gsrv = 0; m_err = 0;
    endtask

    task automatic m_error();
        m_err = 1;
        if (m_ec != 4'd15) m_ec = m_ec + 4'd1;
    endtask

    task automatic m_emit();
        m_overts = 0;
        for (int i = 0; i < m_verts.size(); i++) m_overts[i*VW +: VW] = m_verts[i];
        m_ovalid = 1; m_otype = m_type; m_ocolor = m_color; m_pc = m_pc + 1'b1;
    endtask

    task automatic model_edge(input logic v, input logic [2:0] c, input logic [1:0] pt,
                              input logic [VW-1:0] vd, input logic [CW-1:0] cd,
                              input logic st, input logic lk);
        bit xfer, acc, loaded;
        int need;
        m_err = 0; m_gsrv = 0; loaded = 0;
        if (!lk) begin
            m_in_prim = 0; m_verts.delete(); m_ovalid = 0;
        end else begin
            xfer = m_ovalid && !st;
            acc  = v && (!m_ovalid || !st);
            if (acc) begin
                case (c)
                    3'd1: begin
                        if (m_in_prim) m_error();
                        m_in_prim = 1; m_type = pt; m_verts.delete();
                    end
                    3'd2: begin
                        if (!m_in_prim) m_error();
                        else begin
                            m_verts.push_back(vd);
                            if (m_type == 2'd3) begin
                                if (m_verts.size() > 3) void'(m_verts.pop_front());
                                if (m_verts.size() == 3) begin m_emit(); loaded = 1; end
                            end else begin
                                need = int'(m_type) + 1;
                                if (m_verts.size() == need) begin
                                    m_emit(); loaded = 1; m_verts.delete();
                                end
                            end
                        end
                    end
                    3'd3: m_color = cd;
                    3'd4: begin
                        if (!m_in_prim) m_error();
                        else begin
                            if (m_type == 2'd3 ? m_verts.size() < 3 : m_verts.size() != 0)
                                m_error();
                            m_in_prim = 0; m_verts.delete();
                        end
                    end
                    default: ;
                endcase
            end
            if (xfer && !loaded) m_ovalid = 0;
            if (acc && c == 3'd4 && !m_err_idle(c)) begin end
        end
    endtask

    // Helper kept trivial: GSR pulse is decided separately below.
    function automatic bit m_err_idle(input logic [2:0] c);
        return 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"},  O_PrimValid,      m_ovalid);
        chk({tag, ".type"},   O_PrimType,       m_otype);
        chk({tag, ".verts"},  O_Vertices,       m_overts);
        chk({tag, ".color"},  O_Color,          m_ocolor);
        chk({tag, ".gsr"},    O_GSRValue,       m_gsr);
        chk({tag, ".gsrv"},   O_GSRValue_Valid, m_gsrv);
        chk({tag, ".err"},    O_Error,          m_err);
    endtask

    // One command cycle: drive at the rising edge, DUT acts on the falling edge.
    task automatic cycle(input string tag, input logic v, input logic [2:0] c,
                         input logic [1:0] pt, input logic [VW-1:0] vd,
                         input logic [CW-1:0] cd, input logic st, input logic lk);
        bit was_in_prim, acc;
        I_Valid = v; I_Cmd = c; I_PrimType = pt; I_VertexData = vd; I_ColorData = cd;
        I_GPUStallSignal = st; I_LOCK = lk;
        #1;
        chk({tag, ".ready"}, O_Ready, !m_ovalid || !st);
        was_in_prim = m_in_prim;
        acc = lk && v && (!m_ovalid || !st);
        model_edge(v, c, pt, vd, cd, st, lk);
        if (acc && c == 3'd4 && was_in_prim) begin
            m_gsrv = 1;
            m_gsr  = {m_pc, m_ec, m_type, 1'b0, m_ovalid};
        end
        @(negedge clk); #1;
        check_outputs(tag);
        @(posedge clk);
    endtask

    task automatic cmd(input string tag, input logic [2:0] c, input logic [1:0] pt,
                       input logic [VW-1:0] vd, input logic [CW-1:0] cd, input logic st);
        cycle(tag, 1'b1, c, pt, vd, cd, st, 1'b1);
    endtask

    initial begin
        I_RESET = 1; I_LOCK = 1; I_Valid = 0; I_Cmd = 0; I_PrimType = 0;
        I_VertexData = 0; I_ColorData = 0; I_GPUStallSignal = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", O_Ready, 1'b1);
        check_outputs("rst");
        @(posedge clk);
        I_RESET = 0;

        // Triangle list 1,2,3 then END.
        cmd("tri.b", 3'd1, 2'd2, 0, 0, 0);
        cmd("tri.v1", 3'd2, 0, 30'd1, 0, 0);
        cmd("tri.v2", 3'd2, 0, 30'd2, 0, 0);
        cmd("tri.v3", 3'd2, 0, 30'd3, 0, 0);
        cmd("tri.e", 3'd4, 0, 0, 0, 0);
        cycle("tri.idle", 1'b0, 3'd0, 0, 0, 0, 1'b0, 1'b1);

        // Strip 10..14.
        cmd("strip.b", 3'd1, 2'd3, 0, 0, 0);
        for (int i = 10; i <= 14; i++) cmd("strip.v", 3'd2, 0, VW'(i), 0, 0);
        cmd("strip.e", 3'd4, 0, 0, 0, 0);

        // Stall backpressure on a triangle list.
        cmd("stall.b", 3'd1, 2'd2, 0, 0, 1);
        cmd("stall.v1", 3'd2, 0, 30'd21, 0, 1);
        cmd("stall.v2", 3'd2, 0, 30'd22, 0, 1);
        cmd("stall.v3", 3'd2, 0, 30'd23, 0, 1);
        cmd("stall.v4blk", 3'd2, 0, 30'd24, 0, 1);
        cmd("stall.v4blk2", 3'd2, 0, 30'd24, 0, 1);
        cmd("stall.v4", 3'd2, 0, 30'd24, 0, 0);
        cmd("stall.v5", 3'd2, 0, 30'd25, 0, 0);
        cmd("stall.v6", 3'd2, 0, 30'd26, 0, 1);
        cmd("stall.e", 3'd4, 0, 0, 0, 1);
        cycle("stall.drain", 1'b0, 3'd0, 0, 0, 0, 1'b0, 1'b1);

        // Errors: partial line, vertex in idle, END in idle, BEGIN in collect, short strip.
        cmd("err.b", 3'd1, 2'd1, 0, 0, 0);
        cmd("err.v", 3'd2, 0, 30'd5, 0, 0);
        cmd("err.e", 3'd4, 0, 0, 0, 0);
        cmd("err.vidle", 3'd2, 0, 30'd6, 0, 0);
        cmd("err.eidle", 3'd4, 0, 0, 0, 0);
        cmd("err.b2", 3'd1, 2'd3, 0, 0, 0);
        cmd("err.b3", 3'd1, 2'd3, 0, 0, 0);
        cmd("err.sv", 3'd2, 0, 30'd9, 0, 0);
        cmd("err.se", 3'd4, 0, 0, 0, 0);

        // Colour capture at the completing vertex.
        cmd("col.c1", 3'd3, 0, 0, 16'h00FF, 0);
        cmd("col.b", 3'd1, 2'd0, 0, 0, 0);
        cmd("col.v7", 3'd2, 0, 30'd7, 0, 0);
        cmd("col.c2", 3'd3, 0, 0, 16'h1234, 0);
        cmd("col.v8", 3'd2, 0, 30'd8, 0, 0);
        cmd("col.e", 3'd4, 0, 0, 0, 0);

        // Asynchronous reset between edges with a primitive held.
        cmd("ar.b", 3'd1, 2'd2, 0, 0, 1);
        cmd("ar.v1", 3'd2, 0, 30'd31, 0, 1);
        cmd("ar.v2", 3'd2, 0, 30'd32, 0, 1);
        cmd("ar.v3", 3'd2, 0, 30'd33, 0, 1);
        cmd("ar.v4", 3'd2, 0, 30'd34, 0, 1);
        I_Valid = 0; I_RESET = 1;
        #1;
        model_reset();
        chk("ar.ready", O_Ready, 1'b1);
        check_outputs("ar");
        @(negedge clk); @(posedge clk);
        I_RESET = 0;

        // Flush with I_LOCK low while a primitive is held and one is partial.
        cmd("lk.b", 3'd1, 2'd3, 0, 0, 1);
        cmd("lk.v1", 3'd2, 0, 30'd41, 0, 1);
        cmd("lk.v2", 3'd2, 0, 30'd42, 0, 1);
        cmd("lk.v3", 3'd2, 0, 30'd43, 0, 1);
        cmd("lk.v4", 3'd2, 0, 30'd44, 0, 1);
        cycle("lk.flush", 1'b1, 3'd2, 0, 30'd45, 0, 1'b1, 1'b0);
        cmd("lk.vidle", 3'd2, 0, 30'd46, 0, 0);
        cmd("lk.b2", 3'd1, 2'd0, 0, 0, 0);
        cmd("lk.e2", 3'd4, 0, 0, 0, 0);

        // Primitive counter wrap with back-to-back points.
        cmd("wrap.b", 3'd1, 2'd0, 0, 0, 0);
        for (int i = 0; i < 260; i++) cmd("wrap.v", 3'd2, 0, VW'($urandom), 0, 0);
        cmd("wrap.e", 3'd4, 0, 0, 0, 0);

        // Randomised command stream (errors saturate err_cnt along the way).
        for (int i = 0; i < 600; i++) begin
            logic [2:0] c;
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0:       c = 3'd1;
                1, 2, 3, 4, 5: c = 3'd2;
                6:       c = 3'd3;
                7:       c = 3'd4;
                8:       c = 3'd0;
                default: c = 3'($urandom_range(5, 7));
            endcase
            cycle("rnd", ($urandom % 8) != 0, c, 2'($urandom), VW'($urandom), CW'($urandom),
                  ($urandom % 3) == 0, ($urandom % 20) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
